// File: rtl/led_seq_ctrl_pkg.sv
// led_seq_ctrl_pkg: shared state encodings, button indices and mode-wrap helper for the front-panel sequencer.
package led_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;
  localparam int BTN_RUN  = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_STEP = 2;
  localparam int NUM_BTN  = 3;
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-count debounce and rising-edge press pulse for one button.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic          s1_q, s2_q, deb_q, prev_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= deb_q;
      // any cycle where the synced level agrees with the accepted level restarts the count
      if (s2_q == deb_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign press_o = deb_q & ~prev_q;
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run/pause/step sequencer producing tick enables and pattern mode for the LED engine.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BASE_TICK  = 12_500_000,
  parameter int NUM_MODES  = 4,
  parameter int MODE_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sw,
  input  logic [2:0]        btn,
  output logic              tick,
  output logic [MODE_W-1:0] mode,
  output logic              running,
  output logic              paused,
  output logic              mode_chg
);
  localparam int CNT_W = $clog2(BASE_TICK * 8 + 1);
  logic [NUM_BTN-1:0] press;
  logic [1:0]         sw_s1_q, sw_s2_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               tick_q, tick_d, running_q, paused_q, chg_pend_q, mode_chg_q;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[i]),
      .press_o(press[i])
    );
  end
  assign period = CNT_W'(BASE_TICK) << sw_s2_q;
  always_comb begin
    state_d = (state_q == ST_IDLE)  ? (press[BTN_RUN] ? ST_RUN   : ST_IDLE)  :
              (state_q == ST_RUN)   ? (press[BTN_RUN] ? ST_PAUSE : ST_RUN)   :
              (state_q == ST_PAUSE) ? (press[BTN_RUN] ? ST_RUN   : ST_PAUSE) : ST_IDLE;
    mode_d  = press[BTN_MODE] ? MODE_W'(wrap_inc(int'(mode_q), NUM_MODES)) : mode_q;
    tick_d  = 1'b0;
    cnt_d   = '0;
    // counting only while staying in RUN gives the clear-on-entry and clear-outside-RUN behaviour
    if (state_q == ST_RUN && state_d == ST_RUN && !press[BTN_MODE]) begin
      tick_d = (cnt_q >= period - 1'b1);
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end
    if (state_q == ST_PAUSE && press[BTN_STEP]) tick_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      chg_pend_q <= 1'b0;
      mode_chg_q <= 1'b0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == ST_RUN);
      paused_q   <= (state_d == ST_PAUSE);
      chg_pend_q <= press[BTN_MODE];
      mode_chg_q <= chg_pend_q;
    end
  end
  assign tick     = tick_q;
  assign mode     = mode_q;
  assign running  = running_q;
  assign paused   = paused_q;
  assign mode_chg = mode_chg_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed self-checking bench for led_seq_ctrl with DEB_CYCLES=4, BASE_TICK=8.
module tb_led_seq_ctrl;
  logic       clk, rst;
  logic [1:0] sw;
  logic [2:0] btn;
  logic       tick, running, paused, mode_chg;
  logic [1:0] mode;
  int         checks = 0;
  int         errors = 0;
  led_seq_ctrl #(.DEB_CYCLES(4), .BASE_TICK(8), .NUM_MODES(4), .MODE_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .btn     (btn),
    .tick    (tick),
    .mode    (mode),
    .running (running),
    .paused  (paused),
    .mode_chg(mode_chg)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic expect_tick(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n - 1) begin
      cyc();
      seen += int'(tick);
    end
    chk({tag, "_early"}, seen, 0);
    cyc();
    chk(tag, {31'd0, tick}, 1);
  endtask
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 200);
    chk(tag, {31'd0, tick}, 1);
  endtask
  task automatic press(input int idx, output int nt);
    nt = 0;
    btn[idx] = 1'b1;
    repeat (10) begin
      cyc();
      nt += int'(tick);
    end
    btn[idx] = 1'b0;
    repeat (8) begin
      cyc();
      nt += int'(tick);
    end
  endtask
  task automatic mode_press(input logic [1:0] exp);
    logic [1:0] prev;
    prev = exp - 2'd1;
    btn[1] = 1'b1;
    repeat (6) cyc();
    chk("mode_pre", {30'd0, mode}, {30'd0, prev});
    cyc();
    chk("mode_upd", {30'd0, mode}, {30'd0, exp});
    chk("mode_chg_early", {31'd0, mode_chg}, 0);
    cyc();
    chk("mode_chg_pulse", {31'd0, mode_chg}, 1);
    cyc();
    chk("mode_chg_end", {31'd0, mode_chg}, 0);
    cyc();
    btn[1] = 1'b0;
    repeat (8) cyc();
    chk("mode_hold", {30'd0, mode}, {30'd0, exp});
    chk("mode_running", {31'd0, running}, 1);
  endtask
  initial begin
    int nt, bad;
    rst = 1'b1;
    sw  = 2'd0;
    btn = 3'd0;
    repeat (3) cyc();
    chk("rst_outs", {27'd0, tick, running, paused, mode_chg, 1'b0} | {30'd0, mode}, 0);
    rst = 1'b0;
    nt  = 0;
    bad = 0;
    repeat (100) begin
      cyc();
      nt  += int'(tick);
      bad += int'(running | paused | mode_chg | (mode != 2'd0));
    end
    chk("idle_ticks", nt, 0);
    chk("idle_outs", bad, 0);
    btn[0] = 1'b1;
    repeat (6) cyc();
    chk("run_pre", {31'd0, running}, 0);
    cyc();
    chk("run_at7", {31'd0, running}, 1);
    chk("paused_in_run", {31'd0, paused}, 0);
    repeat (3) cyc();
    btn[0] = 1'b0;
    expect_tick(5, "first_tick");
    expect_tick(8, "period8");
    btn[1] = 1'b1;
    repeat (3) cyc();
    btn[1] = 1'b0;
    bad = 0;
    repeat (12) begin
      cyc();
      bad += int'(mode != 2'd0) + int'(mode_chg);
    end
    chk("short_btn1", bad, 0);
    mode_press(2'd1);
    mode_press(2'd2);
    mode_press(2'd3);
    mode_press(2'd0);
    sw = 2'd3;
    wait_tick("sync_tick1");
    wait_tick("sync_tick2");
    expect_tick(64, "period64");
    repeat (40) cyc();
    sw = 2'd0;
    expect_tick(3, "sw_fast");
    expect_tick(8, "sw_after");
    press(0, nt);
    chk("paused", {31'd0, paused}, 1);
    chk("run_off", {31'd0, running}, 0);
    nt = 0;
    repeat (200) begin
      cyc();
      nt += int'(tick);
    end
    chk("pause_quiet", nt, 0);
    press(2, nt);
    chk("step_one", nt, 1);
    chk("step_stay", {31'd0, paused}, 1);
    press(0, nt);
    chk("resume", {31'd0, running}, 1);
    chk("resume_ticks", nt, 1);
    press(2, nt);
    chk("step_in_run", nt, 2);
    mode_press(2'd1);
    rst    = 1'b1;
    btn[0] = 1'b1;
    cyc();
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_paused", {31'd0, paused}, 0);
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_mode_chg", {31'd0, mode_chg}, 0);
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("held_pre", {31'd0, running}, 0);
    cyc();
    chk("held_run", {31'd0, running}, 1);
    btn = 3'd0;
    repeat (10) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
